// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port backing memory between the fetch (IF) and data (MEM) requesters.
// Holds the memory handshake per access, guards IF against starvation and aborts stuck accesses.
module mem_port_arbiter #(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32,
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          if_req_i,
   input  logic [AW-1:0] if_addr_i,
   output logic [DW-1:0] if_data_o,
   output logic          if_ready_o,
   input  logic          dm_req_i,
   input  logic          dm_we_i,
   input  logic [AW-1:0] dm_addr_i,
   input  logic [DW-1:0] dm_wdata_i,
   output logic [DW-1:0] dm_rdata_o,
   output logic          dm_ready_o,
   output logic          mem_req_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   input  logic [DW-1:0] mem_rdata_i,
   input  logic          mem_ack_i,
   output logic          stall_o,
   output logic          err_o
);

   localparam int unsigned SW = 4;
   localparam int unsigned WW = 8;
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
   localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC, RESP} state_t;

   state_t        state;
   logic [SW-1:0] starve_cnt;
   logic [WW-1:0] wd_cnt;
   logic          grant_dm_c;
   logic          grant_if_c;

   // DM has priority unless IF has been passed over STARVE_MAX times in a row
   assign grant_dm_c = dm_req_i & (~if_req_i | (starve_cnt < STARVE_LIM));
   assign grant_if_c = if_req_i & ~grant_dm_c;

   // Pipeline freezes while any requester still waits; drops in its ready cycle
   assign stall_o = (if_req_i & ~if_ready_o) | (dm_req_i & ~dm_ready_o);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state       <= IDLE;
         starve_cnt  <= '0;
         wd_cnt      <= '0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         if_data_o   <= '0;
         dm_rdata_o  <= '0;
         if_ready_o  <= 1'b0;
         dm_ready_o  <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         if_ready_o <= 1'b0;
         dm_ready_o <= 1'b0;
         err_o      <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_dm_c) begin
                  state       <= DM_ACC;
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= dm_we_i;
                  mem_addr_o  <= dm_addr_i;
                  mem_wdata_o <= dm_wdata_i;
                  if (!if_req_i)
                     starve_cnt <= '0;
                  else if (starve_cnt < STARVE_LIM)
                     starve_cnt <= starve_cnt + SW'(1);
               end else if (grant_if_c) begin
                  state       <= IF_ACC;
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= 1'b0;
                  mem_addr_o  <= if_addr_i;
                  mem_wdata_o <= '0;
                  starve_cnt  <= '0;
               end else begin
                  starve_cnt <= '0;
               end
            end
            IF_ACC, DM_ACC: begin
               if (mem_ack_i || (wd_cnt == WD_LAST)) begin
                  state     <= RESP;
                  mem_req_o <= 1'b0;
                  wd_cnt    <= '0;
                  err_o     <= ~mem_ack_i;
                  if (state == IF_ACC) begin
                     if_ready_o <= 1'b1;
                     if_data_o  <= mem_ack_i ? mem_rdata_i : '0;
                  end else begin
                     dm_ready_o <= 1'b1;
                     // A completed write keeps the last read data
                     if (!mem_ack_i)
                        dm_rdata_o <= '0;
                     else if (!mem_we_o)
                        dm_rdata_o <= mem_rdata_i;
                  end
               end else begin
                  wd_cnt <= wd_cnt + WW'(1);
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; memory side is driven by hand, cycle by cycle.
module tb_mem_port_arbiter;

   logic        clk_i;
   logic        rst_i;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic [31:0] if_data_o;
   logic        if_ready_o;
   logic        dm_req_i;
   logic        dm_we_i;
   logic [31:0] dm_addr_i;
   logic [31:0] dm_wdata_i;
   logic [31:0] dm_rdata_o;
   logic        dm_ready_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;
   logic        mem_ack_i;
   logic        stall_o;
   logic        err_o;

   int n_pass;
   int n_total;
   logic [10:0] if_turn;

   mem_port_arbiter #(
      .AW(32), .DW(32), .STARVE_MAX(4), .TIMEOUT(8)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ready_o(if_ready_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
      .dm_rdata_o(dm_rdata_o), .dm_ready_o(dm_ready_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
      .stall_o(stall_o), .err_o(err_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      rst_i = 1'b0;
      if_req_i = 1'b0;
      if_addr_i = '0;
      dm_req_i = 1'b0;
      dm_we_i = 1'b0;
      dm_addr_i = '0;
      dm_wdata_i = '0;
      mem_rdata_i = '0;
      mem_ack_i = 1'b0;

      // Reset values
      step();
      step();
      check1("rst_mem_req", mem_req_o, 1'b0);
      check1("rst_mem_we", mem_we_o, 1'b0);
      check32("rst_mem_addr", mem_addr_o, 32'h0);
      check32("rst_mem_wdata", mem_wdata_o, 32'h0);
      check32("rst_if_data", if_data_o, 32'h0);
      check32("rst_dm_rdata", dm_rdata_o, 32'h0);
      check1("rst_if_ready", if_ready_o, 1'b0);
      check1("rst_dm_ready", dm_ready_o, 1'b0);
      check1("rst_err", err_o, 1'b0);
      check1("rst_stall", stall_o, 1'b0);
      rst_i = 1'b1;

      // Lone fetch, ack in first access cycle
      if_req_i = 1'b1;
      if_addr_i = 32'h0000_0004;
      #1;
      check1("f1_stall_req", stall_o, 1'b1);
      step();
      check1("f1_mem_req", mem_req_o, 1'b1);
      check32("f1_mem_addr", mem_addr_o, 32'h0000_0004);
      check1("f1_mem_we", mem_we_o, 1'b0);
      check1("f1_stall_acc", stall_o, 1'b1);
      check1("f1_no_ready", if_ready_o, 1'b0);
      mem_ack_i = 1'b1;
      mem_rdata_i = 32'h8C22_0000;
      step();
      mem_ack_i = 1'b0;
      check1("f1_ready", if_ready_o, 1'b1);
      check32("f1_data", if_data_o, 32'h8C22_0000);
      check1("f1_mem_req_drop", mem_req_o, 1'b0);
      check1("f1_stall_ready", stall_o, 1'b0);
      check1("f1_err", err_o, 1'b0);
      if_req_i = 1'b0;
      step();
      check1("f1_ready_pulse", if_ready_o, 1'b0);

      // Stray ack while idle is ignored
      mem_ack_i = 1'b1;
      mem_rdata_i = 32'hFFFF_FFFF;
      step();
      mem_ack_i = 1'b0;
      check1("idle_ack_mem_req", mem_req_o, 1'b0);
      check1("idle_ack_if_ready", if_ready_o, 1'b0);
      check1("idle_ack_dm_ready", dm_ready_o, 1'b0);
      check32("idle_ack_if_data", if_data_o, 32'h8C22_0000);

      // Simultaneous requests: DM first, then IF
      if_req_i = 1'b1;
      if_addr_i = 32'h0000_0040;
      dm_req_i = 1'b1;
      dm_we_i = 1'b0;
      dm_addr_i = 32'h0000_0010;
      step();
      check32("both_dm_addr", mem_addr_o, 32'h0000_0010);
      check1("both_dm_we", mem_we_o, 1'b0);
      mem_ack_i = 1'b1;
      mem_rdata_i = 32'h0000_ABCD;
      step();
      mem_ack_i = 1'b0;
      check1("both_dm_ready", dm_ready_o, 1'b1);
      check1("both_if_not_ready", if_ready_o, 1'b0);
      check32("both_dm_rdata", dm_rdata_o, 32'h0000_ABCD);
      check1("both_stall_if_wait", stall_o, 1'b1);
      dm_req_i = 1'b0;
      step();
      check1("both_resp_gap", mem_req_o, 1'b0);
      step();
      check32("both_if_addr", mem_addr_o, 32'h0000_0040);
      check1("both_if_we", mem_we_o, 1'b0);
      check1("both_if_mem_req", mem_req_o, 1'b1);
      mem_ack_i = 1'b1;
      mem_rdata_i = 32'h0000_0013;
      step();
      mem_ack_i = 1'b0;
      check1("both_if_ready", if_ready_o, 1'b1);
      check32("both_if_data", if_data_o, 32'h0000_0013);
      check32("both_dm_rdata_keep", dm_rdata_o, 32'h0000_ABCD);
      if_req_i = 1'b0;
      step();

      // DM write with three memory wait cycles
      dm_req_i = 1'b1;
      dm_we_i = 1'b1;
      dm_addr_i = 32'h0000_0020;
      dm_wdata_i = 32'hDEAD_BEEF;
      step();
      for (int i = 0; i < 4; i++) begin
         check1("wr_mem_req", mem_req_o, 1'b1);
         check1("wr_mem_we", mem_we_o, 1'b1);
         check32("wr_mem_addr", mem_addr_o, 32'h0000_0020);
         check32("wr_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
         check1("wr_no_ready", dm_ready_o, 1'b0);
         if (i == 3) begin
            mem_ack_i = 1'b1;
            mem_rdata_i = 32'h5555_5555;
         end
         step();
      end
      mem_ack_i = 1'b0;
      check1("wr_ready", dm_ready_o, 1'b1);
      check1("wr_mem_req_drop", mem_req_o, 1'b0);
      check32("wr_rdata_keep", dm_rdata_o, 32'h0000_ABCD);
      dm_req_i = 1'b0;
      dm_we_i = 1'b0;
      step();
      check1("wr_ready_pulse", dm_ready_o, 1'b0);

      // Starvation: both held high, IF forced in every fifth slot
      if_turn = 11'b010_0001_0000;
      if_req_i = 1'b1;
      if_addr_i = 32'h0000_0050;
      dm_req_i = 1'b1;
      dm_addr_i = 32'h0000_0030;
      for (int i = 0; i < 11; i++) begin
         step();
         check32("starve_grant_addr", mem_addr_o, if_turn[i] ? 32'h0000_0050 : 32'h0000_0030);
         mem_ack_i = 1'b1;
         mem_rdata_i = 32'h0000_0100 + 32'(i);
         step();
         mem_ack_i = 1'b0;
         check1("starve_if_ready", if_ready_o, if_turn[i]);
         check1("starve_dm_ready", dm_ready_o, ~if_turn[i]);
         check1("starve_stall_other", stall_o, 1'b1);
         step();
      end
      if_req_i = 1'b0;
      dm_req_i = 1'b0;
      step();

      // Fetch timeout after 8 access cycles
      if_req_i = 1'b1;
      if_addr_i = 32'h0000_0060;
      step();
      for (int i = 0; i < 8; i++) begin
         check1("to_mem_req", mem_req_o, 1'b1);
         check1("to_no_ready", if_ready_o, 1'b0);
         check1("to_no_err", err_o, 1'b0);
         step();
      end
      check1("to_mem_req_drop", mem_req_o, 1'b0);
      check1("to_ready", if_ready_o, 1'b1);
      check1("to_err", err_o, 1'b1);
      check32("to_data_zero", if_data_o, 32'h0);
      if_req_i = 1'b0;
      step();
      check1("to_err_pulse", err_o, 1'b0);
      check1("to_ready_pulse", if_ready_o, 1'b0);

      // Reset in the middle of a DM access
      dm_req_i = 1'b1;
      dm_we_i = 1'b0;
      dm_addr_i = 32'h0000_0070;
      step();
      check1("mid_mem_req", mem_req_o, 1'b1);
      step();
      #3;
      rst_i = 1'b0;
      #1;
      check1("mid_async_drop", mem_req_o, 1'b0);
      check32("mid_addr_clear", mem_addr_o, 32'h0);
      dm_req_i = 1'b0;
      step();
      check1("mid_no_dm_ready", dm_ready_o, 1'b0);
      rst_i = 1'b1;
      if_req_i = 1'b1;
      if_addr_i = 32'h0000_0080;
      step();
      check1("post_mem_req", mem_req_o, 1'b1);
      check32("post_mem_addr", mem_addr_o, 32'h0000_0080);
      mem_ack_i = 1'b1;
      mem_rdata_i = 32'h0000_1234;
      step();
      mem_ack_i = 1'b0;
      check1("post_if_ready", if_ready_o, 1'b1);
      check32("post_if_data", if_data_o, 32'h0000_1234);
      check1("post_no_dm_ready", dm_ready_o, 1'b0);
      check1("post_err", err_o, 1'b0);
      if_req_i = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port backing memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the 5-stage pipelined CPU.
- Grants one access at a time and holds the memory handshake until completion.
- Returns data/ready to the winner and drives a pipeline-wide stall while any request is outstanding.
- Adds an IF anti-starvation counter and an access watchdog.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- STARVE_MAX, 4, consecutive data grants allowed while IF is waiting before IF is forced a slot (1..15).
- TIMEOUT, 255, cycles to wait for mem_ack_i before aborting an access (1..255).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-low reset.
- if_req_i  in  1  fetch request; held with if_addr_i stable until if_ready_o.
- if_addr_i  in  AW  fetch address.
- if_data_o  out  DW  fetched instruction, valid with if_ready_o.
- if_ready_o  out  1  one-cycle completion pulse for fetch.
- dm_req_i  in  1  data request (MemRead|MemWrite); held with operands stable until dm_ready_o.
- dm_we_i  in  1  1=write, 0=read.
- dm_addr_i  in  AW  data address.
- dm_wdata_i  in  DW  write data.
- dm_rdata_o  out  DW  read data, valid with dm_ready_o.
- dm_ready_o  out  1  one-cycle completion pulse for data.
- mem_req_o  out  1  backing-memory request, held until ack.
- mem_we_o  out  1  backing-memory write enable.
- mem_addr_o  out  AW  backing-memory address.
- mem_wdata_o  out  DW  backing-memory write data.
- mem_rdata_i  in  DW  backing-memory read data, valid with mem_ack_i.
- mem_ack_i  in  1  backing-memory completion, single cycle.
- stall_o  out  1  freeze PC/IFID/IDEX/EXMEM/MEMWB.
- err_o  out  1  one-cycle pulse alongside ready when an access timed out.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State goes to IDLE immediately.
  - All registered outputs go to 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, if_data_o, dm_rdata_o, both ready pulses, err_o.
  - starve_cnt and wd_cnt clear.
  - A reset mid-access drops mem_req_o at once; the interrupted access produces no ready pulse.
- States: IDLE, IF_ACC, DM_ACC, RESP.
- IDLE:
  - Requests are sampled only in this state.
  - Grant DM if dm_req_i & (!if_req_i | starve_cnt<STARVE_MAX).
  - Otherwise grant IF if if_req_i.
  - On grant, latch addr/we/wdata (we=0 for IF) into the mem_* registers and the owner flag.
  - Go to IF_ACC or DM_ACC; mem_req_o=1 from the next cycle.
  - With no request, stay in IDLE.
- starve_cnt (4-bit, saturating at STARVE_MAX):
  - Increments on a DM grant while if_req_i=1.
  - Clears on an IF grant, or in IDLE when if_req_i=0.
  - When starve_cnt==STARVE_MAX and both requests are present, IF wins.
- IF_ACC / DM_ACC:
  - mem_req_o and mem_* operands are held stable.
  - wd_cnt increments each cycle.
  - On mem_ack_i: capture mem_rdata_i into the owner's data register (a DM write leaves dm_rdata_o unchanged), drop mem_req_o, go to RESP.
  - If wd_cnt reaches TIMEOUT without ack: drop mem_req_o, load owner data with 0, set the error flag, go to RESP.
  - wd_cnt clears on leaving the state.
- RESP:
  - Exactly one cycle, then IDLE.
  - The owner's ready pulses high; err_o pulses if the access was aborted.
  - Requests are not sampled in RESP. A requester may keep req high through RESP to present a new request, which is sampled in the following IDLE cycle.
- Minimum latency, grant to ready: with ack in the first ACC cycle, grant at T, mem_req_o at T+1, ack at T+1, ready at T+2. Each extra memory wait cycle adds one.
- stall_o = (if_req_i & !if_ready_o) | (dm_req_i & !dm_ready_o), combinational.
  - Low in the ready cycle, so the pipeline advances exactly once per completed access.
- mem_ack_i outside IF_ACC/DM_ACC is ignored.
- Address is passed unmodified; no alignment checking.

Test Plan:
- Reset then lone fetch: if_addr_i=0x00000004; memory acks 1 cycle after req with 0x8C220000 -> mem_req_o high 1 cycle, if_ready_o pulses at grant+2, if_data_o=0x8C220000, stall_o high until that cycle.
- Simultaneous if_req/dm_req, DM read addr 0x10 returns 0x0000ABCD -> DM served first, dm_ready_o with dm_rdata_o=0x0000ABCD, then IF served next IDLE; mem_we_o=0 throughout.
- DM write addr 0x20, data 0xDEADBEEF, memory 3 wait cycles -> mem_we_o=1, mem_addr_o=0x20, mem_wdata_o=0xDEADBEEF stable 4 cycles; dm_ready_o 1 cycle after ack; dm_rdata_o unchanged.
- Starvation: dm_req_i and if_req_i held high continuously, STARVE_MAX=4 -> grant order DM,DM,DM,DM,IF,DM..., starve_cnt returns to 0 after the IF grant.
- Timeout: TIMEOUT=8, mem_ack_i never asserted on a fetch -> mem_req_o drops after 8 cycles; if_ready_o and err_o pulse together; if_data_o=0.
- Reset mid-access: rst_i low during DM_ACC -> mem_req_o=0 asynchronously, no dm_ready_o; after release, a fresh IF request completes normally.
